// File: rtl/rr_arbiter_4ch_pkg.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4ch_pkg
//   Shared definitions for the 4-channel round-robin arbiter slice: channel
//   count, index width, FSM state encoding and the winner-search result type.
// -----------------------------------------------------------------------------
package rr_arbiter_4ch_pkg;

    localparam int NCH   = 4;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

endpackage

// File: rtl/rr_arbiter_4ch_if.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4ch_if
//   Request/grant bundle between the requester channels and the arbiter.
//   req        : per-channel request, active-high
//   gnt_valid  : a grant is active this cycle
//   gnt_idx    : granted channel (valid only with gnt_valid)
//   gnt_n      : active-low one-hot select strobes, all ones when idle
//   expired    : one-cycle pulse when a grant was revoked by the hold limit
//   master     : requester side, slave : arbiter side
// -----------------------------------------------------------------------------
interface rr_arbiter_4ch_if;
    import rr_arbiter_4ch_pkg::*;

    logic [NCH-1:0]   req;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic [NCH-1:0]   gnt_n;
    logic             expired;

    modport master (
        output req,
        input  gnt_valid, gnt_idx, gnt_n, expired
    );

    modport slave (
        input  req,
        output gnt_valid, gnt_idx, gnt_n, expired
    );

endinterface

// File: rtl/rr_arbiter_4ch_decoder.sv
// -----------------------------------------------------------------------------
// decoder_2x4_zhegalkin
//   2-to-4 decoder with active-low outputs, each output written as its
//   Zhegalkin (AND/XOR) polynomial of the two address bits.
//   i_a    : 2-bit select
//   o_y_n  : active-low one-hot decode of i_a
// -----------------------------------------------------------------------------
module decoder_2x4_zhegalkin (
    input  logic [1:0] i_a,
    output logic [3:0] o_y_n
);

    logic       w_a0;
    logic       w_a1;
    logic       w_a01;
    logic [3:0] w_y;

    assign w_a0  = i_a[0];
    assign w_a1  = i_a[1];
    assign w_a01 = w_a0 & w_a1;

    // ~a1&~a0 = 1^a0^a1^a0a1, a0&~a1 = a0^a0a1, a1&~a0 = a1^a0a1
    assign w_y[0] = 1'b1 ^ w_a0 ^ w_a1 ^ w_a01;
    assign w_y[1] = w_a0 ^ w_a01;
    assign w_y[2] = w_a1 ^ w_a01;
    assign w_y[3] = w_a01;

    assign o_y_n = ~w_y;

endmodule

// File: rtl/rr_arbiter_4ch.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4ch
//   Round-robin arbiter sharing one resource among 4 requesters, with a
//   hold-time limit while others wait and an optional dead cycle between
//   grants for bus turnaround.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   arb    : request/grant bundle (slave side)
//   Parameters: MAX_HOLD (>=2) max consecutive grant cycles while another
//   request is pending; GAP_EN inserts one idle cycle after each release.
// -----------------------------------------------------------------------------
module rr_arbiter_4ch
    import rr_arbiter_4ch_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter bit GAP_EN   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_arbiter_4ch_if.slave   arb
);

    localparam int               CNT_W     = $clog2(MAX_HOLD) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t       r_state;
    logic             r_gnt_valid;
    logic [IDX_W-1:0] r_gnt_idx;
    logic             r_expired;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [IDX_W-1:0] r_last_idx;

    logic [NCH-1:0]   w_dec_n;
    logic             w_others;
    pick_t            w_pick;

    // First requesting channel after 'last', wrapping, so 'last' is tried last.
    function automatic pick_t rr_pick(input logic [NCH-1:0]   req,
                                      input logic [IDX_W-1:0] last);
        pick_t            res;
        logic [IDX_W-1:0] cand;
        res = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            cand = last + IDX_W'(k);
            if (!res.found && req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

    assign w_pick = rr_pick(arb.req, r_last_idx);

    decoder_2x4_zhegalkin u_dec (
        .i_a   (r_gnt_idx),
        .o_y_n (w_dec_n)
    );

    // The decoder's zero bit marks the current owner, so req & dec_n is
    // exactly the set of other channels still asking.
    assign w_others = |(arb.req & w_dec_n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_gnt_valid <= 1'b0;
            r_gnt_idx   <= '0;
            r_expired   <= 1'b0;
            r_hold_cnt  <= '0;
            r_last_idx  <= IDX_W'(NCH - 1);
        end else begin
            r_expired <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick.found) begin
                        r_state     <= ST_GRANT;
                        r_gnt_valid <= 1'b1;
                        r_gnt_idx   <= w_pick.idx;
                        r_last_idx  <= w_pick.idx;
                        r_hold_cnt  <= '0;
                    end
                end
                ST_GRANT: begin
                    if (!arb.req[r_gnt_idx]) begin
                        r_state     <= GAP_EN ? ST_GAP : ST_IDLE;
                        r_gnt_valid <= 1'b0;
                        r_hold_cnt  <= '0;
                    end else if (r_hold_cnt == HOLD_LAST && w_others) begin
                        r_state     <= GAP_EN ? ST_GAP : ST_IDLE;
                        r_gnt_valid <= 1'b0;
                        r_hold_cnt  <= '0;
                        r_expired   <= 1'b1;
                    end else if (r_hold_cnt != HOLD_LAST) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    assign arb.gnt_valid = r_gnt_valid;
    assign arb.gnt_idx   = r_gnt_idx;
    assign arb.expired   = r_expired;
    assign arb.gnt_n     = r_gnt_valid ? w_dec_n : '1;

endmodule

// File: tb/tb_rr_arbiter_4ch.sv
module tb_rr_arbiter_4ch;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_v;

    int n_checks = 0;
    int n_errors = 0;

    rr_arbiter_4ch_if ifa ();
    rr_arbiter_4ch_if ifb ();

    rr_arbiter_4ch #(.MAX_HOLD(16), .GAP_EN(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (ifa.slave)
    );

    rr_arbiter_4ch #(.MAX_HOLD(4), .GAP_EN(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner (-1 = nobody), cycles owned so far, pointer of
    // the most recent winner, dead cycles still to wait before arbitrating.
    int m_owner[2];
    int m_held[2];
    int m_ptr[2];
    int m_dead[2];
    bit m_exp[2];
    int m_maxh[2] = '{16, 4};
    int m_gap[2]  = '{1, 0};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input logic [3:0] v);
        req_v   = v;
        ifa.req = v;
        ifb.req = v;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1;
            m_held[d]  = 0;
            m_ptr[d]   = 3;
            m_dead[d]  = 0;
            m_exp[d]   = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [3:0] mask;
        int         c;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_owner[d] = -1; m_held[d] = 0; m_ptr[d] = 3; m_dead[d] = 0; m_exp[d] = 1'b0;
                continue;
            end
            m_exp[d] = 1'b0;
            if (m_owner[d] >= 0) begin
                m_held[d]++;
                mask = req_v;
                mask[m_owner[d]] = 1'b0;
                if (!req_v[m_owner[d]]) begin
                    m_owner[d] = -1;
                    m_dead[d]  = m_gap[d];
                end else if (m_held[d] >= m_maxh[d] && mask != 4'b0000) begin
                    m_owner[d] = -1;
                    m_dead[d]  = m_gap[d];
                    m_exp[d]   = 1'b1;
                end
            end else if (m_dead[d] > 0) begin
                m_dead[d]--;
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    c = (m_ptr[d] + k) % 4;
                    if (req_v[c]) begin
                        m_owner[d] = c;
                        m_ptr[d]   = c;
                        m_held[d]  = 0;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic check_dut(input string n, input int d, input logic v, input logic [1:0] idx,
                             input logic [3:0] gn, input logic ex);
        logic       exp_v;
        logic [3:0] exp_n;
        exp_v = (m_owner[d] >= 0);
        exp_n = 4'b1111;
        if (exp_v) exp_n[m_owner[d]] = 1'b0;
        check_eq({n, "_valid"}, 32'(v), 32'(exp_v));
        check_eq({n, "_gnt_n"}, 32'(gn), 32'(exp_n));
        check_eq({n, "_expired"}, 32'(ex), 32'(m_exp[d]));
        if (exp_v) check_eq({n, "_idx"}, 32'(idx), 32'(m_owner[d]));
        if (v) check_eq({n, "_onehot"}, 32'($countones(~gn)), 32'd1);
    endtask

    task automatic compare_all();
        check_dut("A", 0, ifa.gnt_valid, ifa.gnt_idx, ifa.gnt_n, ifa.expired);
        check_dut("B", 1, ifb.gnt_valid, ifb.gnt_idx, ifb.gnt_n, ifb.expired);
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         cnt[4];
        int         order[$];
        int         exp_order[5] = '{0, 1, 2, 3, 0};
        logic       prev_v;
        int         run0;
        bit         seen1;
        int         n_exp;
        logic [3:0] r;

        // Reset held with all requests asserted
        rst_n = 1'b0;
        set_req(4'b1111);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_eq("t1_rst_valid", 32'(ifa.gnt_valid), 32'd0);
        check_eq("t1_rst_gnt_n", 32'(ifa.gnt_n), 32'hF);
        check_eq("t1_rst_expired", 32'(ifa.expired), 32'd0);
        check_eq("t1_rst_gnt_n_b", 32'(ifb.gnt_n), 32'hF);
        rst_n = 1'b1;
        tick();
        check_eq("t1_idx", 32'(ifa.gnt_idx), 32'd0);
        check_eq("t1_gnt_n", 32'(ifa.gnt_n), 32'hE);

        // Every requester drops after 3 grant cycles; ch0 comes back at the end
        do_reset();
        set_req(4'b1111);
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        prev_v = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            if (ifa.gnt_valid && !prev_v) order.push_back(int'(ifa.gnt_idx));
            prev_v = ifa.gnt_valid;
            r = req_v;
            if (ifa.gnt_valid) begin
                cnt[ifa.gnt_idx]++;
                if (cnt[ifa.gnt_idx] == 3) r[ifa.gnt_idx] = 1'b0;
            end
            if (r == 4'b0000 && order.size() == 4) r = 4'b0001;
            set_req(r);
        end
        check_eq("t2_order_len", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < order.size()) check_eq($sformatf("t2_order%0d", i), 32'(order[i]), 32'(exp_order[i]));

        // ch0 never drops while ch1 waits: hold limit revokes ch0
        do_reset();
        set_req(4'b0011);
        run0  = 0;
        seen1 = 1'b0;
        n_exp = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            tick();
            if (ifa.gnt_valid && ifa.gnt_idx == 2'd0) run0++;
            if (ifa.gnt_valid && ifa.gnt_idx == 2'd1) seen1 = 1'b1;
            if (ifa.expired) begin
                n_exp++;
                check_eq("t3_run_at_expiry", 32'(run0), 32'd16);
                check_eq("t3_valid_at_expiry", 32'(ifa.gnt_valid), 32'd0);
            end
        end
        check_eq("t3_expired_count", 32'(n_exp), 32'd1);
        check_eq("t3_ch1_granted", 32'(seen1), 32'd1);

        // Sole requester keeps the grant indefinitely
        do_reset();
        set_req(4'b0100);
        n_exp = 0;
        tick();
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            if (ifa.expired || ifb.expired) n_exp++;
        end
        check_eq("t4_idx", 32'(ifa.gnt_idx), 32'd2);
        check_eq("t4_no_expiry", 32'(n_exp), 32'd0);

        // Asynchronous reset in the middle of a ch3 grant
        do_reset();
        set_req(4'b1000);
        tick();
        tick();
        check_eq("t5_pre_idx", 32'(ifa.gnt_idx), 32'd3);
        @(posedge clk);
        model_step();
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("t5_async_gnt_n", 32'(ifa.gnt_n), 32'hF);
        check_eq("t5_async_valid", 32'(ifa.gnt_valid), 32'd0);
        check_eq("t5_async_gnt_n_b", 32'(ifb.gnt_n), 32'hF);
        model_reset();
        @(negedge clk);
        compare_all();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("t5_post_idx", 32'(ifa.gnt_idx), 32'd3);
        check_eq("t5_post_valid", 32'(ifa.gnt_valid), 32'd1);

        // No dead cycle configuration (dut_b): ch0 releases, ch2 follows
        do_reset();
        set_req(4'b0101);
        tick();
        check_eq("t6_b_idx0", 32'(ifb.gnt_idx), 32'd0);
        tick();
        set_req(4'b0100);
        tick();
        check_eq("t6_b_gap_valid", 32'(ifb.gnt_valid), 32'd0);
        tick();
        check_eq("t6_b_valid", 32'(ifb.gnt_valid), 32'd1);
        check_eq("t6_b_idx2", 32'(ifb.gnt_idx), 32'd2);

        // Randomised traffic: sticky requests with occasional toggles
        r = 4'($urandom_range(15));
        set_req(r);
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            for (int b = 0; b < 4; b++)
                if ($urandom_range(7) == 0) r[b] = ~r[b];
            if ($urandom_range(63) == 0) r = 4'b0000;
            set_req(r);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
